// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, flag indices and execute-stage FSM encoding
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_LSH  = 4'd8;
  localparam logic [3:0] OP_ASHU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  // Bit positions inside the {N,Z,F,L,C} flags register
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - one-step-per-cycle shifter and shift-add multiplier
module alu_iter_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             mul,
  input  logic             arith,
  input  logic             left,
  input  logic [CNT_W-1:0] steps,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] result_next
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;
  logic             mode_mul;
  logic             mode_arith;
  logic             mode_left;

  assign busy = (count != '0);
  assign last = (count == CNT_W'(1));

  // The owner captures result_next on the last step, saving a cycle after the count expires
  always_comb begin
    result_next = acc;
    if (mode_mul) begin
      result_next = mplier[0] ? (acc + mcand) : acc;
    end else if (mode_left) begin
      result_next = {acc[WIDTH-2:0], 1'b0};
    end else if (mode_arith) begin
      result_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
    end else begin
      result_next = {1'b0, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
      mode_mul   <= 1'b0;
      mode_arith <= 1'b0;
      mode_left  <= 1'b0;
    end else if (load) begin
      acc        <= mul ? '0 : a;
      mcand      <= a;
      mplier     <= b;
      count      <= steps;
      mode_mul   <= mul;
      mode_arith <= arith;
      mode_left  <= left;
    end else if (busy) begin
      acc    <= result_next;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      count  <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute stage: single-cycle ALU, flags and regfile write-back FSM
module alu_exec
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [3:0]       dst_addr,
  input  logic [WIDTH-1:0] dst_data,
  input  logic [WIDTH-1:0] src_data,
  output logic             ready,
  output logic             done,
  output logic             wb_write,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [4:0]       flags
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);

  state_t           state;
  logic [3:0]       addr_q;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flags;
  logic             alu_write;
  logic [WIDTH:0]   sum;
  logic [4:0]       amt_mag;
  logic             shift_op;
  logic             iter_op;
  logic [CNT_W-1:0] iter_steps;
  logic             iter_load;
  logic             iter_busy;
  logic             iter_last;
  logic [WIDTH-1:0] iter_result;

  // Shift amount is a signed 5-bit field: -16..15, magnitude up to 16
  assign amt_mag    = src_data[4] ? (5'd0 - src_data[4:0]) : src_data[4:0];
  assign shift_op   = (opcode == OP_LSH) || (opcode == OP_ASHU);
  assign iter_op    = (shift_op && (src_data[4:0] != 5'd0)) || (opcode == OP_MUL);
  assign iter_steps = (opcode == OP_MUL) ? CNT_W'(MUL_STEPS) : CNT_W'(amt_mag);
  assign iter_load  = (state == IDLE) && start && iter_op;

  alu_iter_unit #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (iter_load),
    .mul        (opcode == OP_MUL),
    .arith      (opcode == OP_ASHU),
    .left       (!src_data[4]),
    .steps      (iter_steps),
    .a          (dst_data),
    .b          (src_data),
    .busy       (iter_busy),
    .last       (iter_last),
    .result_next(iter_result)
  );

  always_comb begin
    alu_res   = '0;
    alu_flags = flags;
    alu_write = 1'b1;
    sum       = '0;
    case (opcode)
      OP_ADD, OP_ADDC: begin
        sum = {1'b0, dst_data} + {1'b0, src_data}
            + {{WIDTH{1'b0}}, (opcode == OP_ADDC) & flags[FLAG_C]};
        alu_res           = sum[WIDTH-1:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_F] = (dst_data[WIDTH-1] == src_data[WIDTH-1]) &&
                            (sum[WIDTH-1] != dst_data[WIDTH-1]);
      end
      OP_SUB: begin
        sum               = {1'b0, dst_data} - {1'b0, src_data};
        alu_res           = sum[WIDTH-1:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_F] = (dst_data[WIDTH-1] != src_data[WIDTH-1]) &&
                            (sum[WIDTH-1] != dst_data[WIDTH-1]);
      end
      OP_CMP: begin
        alu_write         = 1'b0;
        alu_res           = wb_data;
        alu_flags[FLAG_Z] = (dst_data == src_data);
        alu_flags[FLAG_L] = (dst_data < src_data);
        alu_flags[FLAG_N] = ($signed(dst_data) < $signed(src_data));
      end
      OP_AND:           alu_res = dst_data & src_data;
      OP_OR:            alu_res = dst_data | src_data;
      OP_XOR:           alu_res = dst_data ^ src_data;
      OP_MOV:           alu_res = src_data;
      OP_LSH, OP_ASHU:  alu_res = dst_data;
      OP_MUL:           alu_res = '0;
      default: begin
        alu_write = 1'b0;
        alu_res   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      wb_write <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      flags    <= '0;
      addr_q   <= '0;
    end else begin
      done     <= 1'b0;
      wb_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ready  <= 1'b0;
            addr_q <= dst_addr;
            if (iter_op) begin
              state <= ITER;
            end else begin
              state    <= DONE;
              done     <= 1'b1;
              wb_write <= alu_write;
              wb_addr  <= dst_addr;
              wb_data  <= alu_res;
              flags    <= alu_flags;
            end
          end
        end
        ITER: begin
          if (iter_last) begin
            state    <= DONE;
            done     <= 1'b1;
            wb_write <= 1'b1;
            wb_addr  <= addr_q;
            wb_data  <= iter_result;
          end else if (!iter_busy) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard bench for alu_exec
module tb_alu_exec;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [3:0]  dst_addr = '0;
  logic [15:0] dst_data = '0;
  logic [15:0] src_data = '0;
  logic        ready;
  logic        done;
  logic        wb_write;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [4:0]  flags;

  alu_exec dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .opcode  (opcode),
    .dst_addr(dst_addr),
    .dst_data(dst_data),
    .src_data(src_data),
    .ready   (ready),
    .done    (done),
    .wb_write(wb_write),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .flags   (flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        write;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        chk_data;
    logic [4:0]  flags;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] m_flags = '0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference behaviour; m_flags tracks the architectural flags in issue order
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output exp_t e, output int lat);
    logic [16:0]        s;
    logic [31:0]        p;
    logic signed [15:0] sa;
    int                 amt;
    e.write    = 1'b1;
    e.chk_data = 1'b1;
    e.data     = '0;
    e.addr     = '0;
    e.cyc      = 0;
    lat        = 1;
    amt        = (b[4] ? -32 : 0) + int'(b[4:0]);
    case (op)
      4'd0, 4'd1: begin
        s = {1'b0, a} + {1'b0, b} + 17'((op == 4'd1) && m_flags[0]);
        e.data = s[15:0];
        m_flags[0] = s[16];
        m_flags[2] = (a[15] == b[15]) && (s[15] != a[15]);
      end
      4'd2: begin
        s = {1'b0, a} - {1'b0, b};
        e.data = s[15:0];
        m_flags[0] = (a < b);
        m_flags[2] = (a[15] != b[15]) && (s[15] != a[15]);
      end
      4'd3: begin
        e.write = 1'b0;
        e.chk_data = 1'b0;
        m_flags[3] = (a == b);
        m_flags[1] = (a < b);
        m_flags[4] = ($signed(a) < $signed(b));
      end
      4'd4: e.data = a & b;
      4'd5: e.data = a | b;
      4'd6: e.data = a ^ b;
      4'd7: e.data = b;
      4'd8, 4'd9: begin
        if (amt > 0) begin
          e.data = a << amt;
          lat = amt + 1;
        end else if (amt < 0) begin
          if (op == 4'd8) begin
            e.data = a >> (-amt);
          end else begin
            sa = a;
            sa = sa >>> (-amt);
            e.data = sa;
          end
          lat = 1 - amt;
        end else begin
          e.data = a;
        end
      end
      4'd10: begin
        p = a * b;
        e.data = p[15:0];
        lat = 17;
      end
      default: e.write = 1'b0;
    endcase
    e.flags = m_flags;
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [3:0] addr,
                          input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   lat;
    model(op, a, b, e, lat);
    e.addr = addr;
    e.cyc  = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] addr,
                       input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check_eq("ready_timeout", 32'(ready), 1);
    opcode = op; dst_addr = addr; dst_data = a; src_data = b; start = 1'b1;
    push_exp(op, addr, a, b);
    @(negedge clk);
    start = 1'b0;
    opcode = 4'($urandom); dst_addr = 4'($urandom);
    dst_data = 16'($urandom); src_data = 16'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && wb_write && !done) check_eq("wb_write_without_done", 1, 0);
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", {28'd0, wb_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_eq("done_cycle", cyc, e.cyc);
        check_eq("wb_write", 32'(wb_write), 32'(e.write));
        if (e.write) check_eq("wb_addr", 32'(wb_addr), 32'(e.addr));
        if (e.chk_data) check_eq("wb_data", 32'(wb_data), 32'(e.data));
        check_eq("flags", 32'(flags), 32'(e.flags));
      end
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(ready), 1);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_wb_write", 32'(wb_write), 0);
    check_eq("rst_wb_addr", 32'(wb_addr), 0);
    check_eq("rst_wb_data", 32'(wb_data), 0);
    check_eq("rst_flags", 32'(flags), 0);
    reset_n = 1'b1;

    issue(OP_ADD, 4'd3, 16'h7FFF, 16'h0001);
    drain();
    issue(OP_ADD, 4'd1, 16'hFFFF, 16'h0001);
    issue(OP_ADDC, 4'd2, 16'hFFFF, 16'h0000);
    drain();
    issue(OP_CMP, 4'd4, 16'h8000, 16'h0001);
    drain();

    issue(OP_LSH, 4'd5, 16'h0001, 16'h0003);
    issue(OP_ASHU, 4'd6, 16'h8000, 16'h0010);
    issue(OP_LSH, 4'd7, 16'h8000, 16'h0010);
    issue(OP_LSH, 4'd8, 16'hF0F0, 16'h001F);
    issue(OP_ASHU, 4'd9, 16'h1234, 16'h0000);
    drain();

    issue(OP_MUL, 4'd7, 16'd300, 16'd300);
    repeat (3) begin
      @(negedge clk);
      check_eq("iter_ready_low", 32'(ready), 0);
      start = 1'b1; opcode = OP_MOV; src_data = 16'hDEAD;
      @(negedge clk);
      start = 1'b0;
    end
    drain();

    issue(4'd13, 4'd8, 16'h1234, 16'h5678);
    drain();

    opcode = OP_ADD; dst_addr = 4'd10; dst_data = 16'h1111; src_data = 16'h2222; start = 1'b1;
    push_exp(OP_ADD, 4'd10, 16'h1111, 16'h2222);
    @(negedge clk);
    check_eq("b2b_ready_n1", 32'(ready), 0);
    opcode = OP_MOV; dst_addr = 4'd11; src_data = 16'hDEAD;
    @(negedge clk);
    check_eq("b2b_ready_n2", 32'(ready), 1);
    opcode = OP_SUB; dst_addr = 4'd12; dst_data = 16'h0005; src_data = 16'h0007;
    push_exp(OP_SUB, 4'd12, 16'h0005, 16'h0007);
    @(negedge clk);
    opcode = OP_MOV; dst_addr = 4'd13; src_data = 16'hBEEF;
    @(negedge clk);
    start = 1'b0;
    drain();

    issue(OP_MUL, 4'd9, 16'h1234, 16'h4321);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_done", 32'(done), 0);
    check_eq("mid_rst_wb_write", 32'(wb_write), 0);
    check_eq("mid_rst_wb_addr", 32'(wb_addr), 0);
    check_eq("mid_rst_wb_data", 32'(wb_data), 0);
    check_eq("mid_rst_flags", 32'(flags), 0);
    check_eq("mid_rst_ready", 32'(ready), 1);
    sb.delete();
    m_flags = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("post_rst_ready", 32'(ready), 1);

    for (int i = 0; i < 30; i++) begin
      issue(4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
